// File: rtl/sramlike_mem_arbiter.sv
// sramlike_mem_arbiter
//   Merges the core's instruction port (if_*) and data port (mem_*) onto one
//   downstream SRAM-like port (out_*). Up to DEPTH accepted requests may be
//   outstanding. Responses come back in acceptance order. A small owner FIFO
//   remembers which port issued each request, so that each out_data_ok is
//   routed back to the right port.
//
// Ports
//   clk, reset                       clock and synchronous active-high reset
//   if_ben/din/wr/addr    -> in      instruction request (ben != 0 means valid)
//   if_addr_ok/data_ok/dout <- out   instruction handshake and response
//   mem_*                            same as if_*, for the data port
//   out_ben/din/wr/addr   <- out     downstream request (ben == 0 means idle)
//   out_addr_ok/data_ok/dout -> in   downstream handshake and response
//   err_orphan            <- out     sticky flag: a response arrived with nothing in flight
module sramlike_mem_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  if_ben,
  input  logic [31:0] if_din,
  input  logic        if_wr,
  input  logic [31:0] if_addr,
  output logic        if_addr_ok,
  output logic        if_data_ok,
  output logic [31:0] if_dout,
  input  logic [3:0]  mem_ben,
  input  logic [31:0] mem_din,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_dout,
  output logic [3:0]  out_ben,
  output logic [31:0] out_din,
  output logic        out_wr,
  output logic [31:0] out_addr,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_dout,
  output logic        err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;      // 0 = instruction, 1 = data
  logic [SW-1:0]   cnt_q, cnt_d;          // starvation counter
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fifo_q [DEPTH];
  logic            fifo_d [DEPTH];
  logic            err_q, err_d;
  logic            rst_dly_q, rst_dly_d;

  logic block, full, if_req, mem_req, starved;
  logic present, sel, accept, push, pop, orphan, head;

  always_comb begin
    // Outputs stay quiet during reset and the cycle after it.
    block   = reset | rst_dly_q;
    full    = (count_q == CW'(DEPTH));
    if_req  = |if_ben;
    mem_req = |mem_ben;
    starved = (cnt_q == SW'(STARVE_LIMIT));

    present = 1'b0;
    sel     = owner_q;
    state_d = state_q;
    owner_d = owner_q;

    case (state_q)
      IDLE: begin
        if (!block && !full && (if_req || mem_req)) begin
          present = 1'b1;
          // Data wins unless the instruction port has waited too long.
          sel     = ~(if_req & (~mem_req | starved));
        end
      end
      HOLD: begin
        // A locked owner is never preempted. A full FIFO cannot occur here,
        // because the grant was made while a slot was free.
        if (!block) begin
          present = 1'b1;
          sel     = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = present & out_addr_ok;
    if (present) begin
      state_d = accept ? IDLE : HOLD;
      owner_d = sel;
    end

    out_ben  = 4'h0;
    out_din  = 32'h0;
    out_wr   = 1'b0;
    out_addr = 32'h0;
    if (present) begin
      out_ben  = sel ? mem_ben  : if_ben;
      out_din  = sel ? mem_din  : if_din;
      out_wr   = sel ? mem_wr   : if_wr;
      out_addr = sel ? mem_addr : if_addr;
    end
    if_addr_ok  = accept & ~sel;
    mem_addr_ok = accept & sel;

    // Owner FIFO. A slot freed by a pop only becomes usable in the next
    // cycle, because the full flag is computed from the registered count.
    push   = accept;
    pop    = ~block & out_data_ok & (count_q != '0);
    orphan = ~block & out_data_ok & (count_q == '0);
    head   = fifo_q[rd_ptr_q];

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = sel;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if_data_ok  = pop & ~head;
    mem_data_ok = pop & head;
    if_dout     = if_data_ok  ? out_dout : 32'h0;
    mem_dout    = mem_data_ok ? out_dout : 32'h0;

    // The starvation counter only counts data grants made while an
    // instruction request is actually waiting.
    cnt_d = cnt_q;
    if (accept && !sel)
      cnt_d = '0;
    else if (!if_req)
      cnt_d = '0;
    else if (accept && sel && !starved)
      cnt_d = cnt_q + 1'b1;

    err_d      = err_q | orphan;
    rst_dly_d  = reset;
    err_orphan = err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      rst_dly_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      rst_dly_q <= rst_dly_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_sramlike_mem_arbiter.sv
// Testbench for sramlike_mem_arbiter. The bench drives directed vectors and
// checks them against literal expectations. A queue-based reference model
// also checks every output on every cycle.
module tb_sramlike_mem_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  if_ben = '0, mem_ben = '0;
  logic [31:0] if_din = '0, mem_din = '0, if_addr = '0, mem_addr = '0;
  logic        if_wr = 1'b0, mem_wr = 1'b0;
  logic        out_addr_ok = 1'b0, out_data_ok = 1'b0;
  logic [31:0] out_dout = '0;
  logic        if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok, out_wr, err_orphan;
  logic [31:0] if_dout, mem_dout, out_din, out_addr;
  logic [3:0]  out_ben;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sramlike_mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_ben(if_ben), .if_din(if_din), .if_wr(if_wr), .if_addr(if_addr),
    .if_addr_ok(if_addr_ok), .if_data_ok(if_data_ok), .if_dout(if_dout),
    .mem_ben(mem_ben), .mem_din(mem_din), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_dout(mem_dout),
    .out_ben(out_ben), .out_din(out_din), .out_wr(out_wr), .out_addr(out_addr),
    .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_dout(out_dout),
    .err_orphan(err_orphan)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Reference model. The in-flight owners are held in a queue (0 = if,
  // 1 = mem). "pending" is the owner locked by a request that was shown
  // downstream but not yet accepted.
  int q[$];
  int pending = -1;
  int starve = 0;
  bit err_m = 1'b0;
  bit after_rst = 1'b0;

  initial begin : model
    bit blocked, present, accepted, popped, orphan;
    int own, head;
    logic [70:0] exp_req;
    logic [66:0] exp_rsp;
    forever begin
      @(negedge clk);
      blocked = reset || after_rst;
      present = 1'b0;
      own = 0;
      if (!blocked && pending >= 0) begin
        present = 1'b1;
        own = pending;
      end else if (!blocked && q.size() < DEPTH && (if_ben != 0 || mem_ben != 0)) begin
        present = 1'b1;
        own = (if_ben != 0 && (mem_ben == 0 || starve == LIMIT)) ? 0 : 1;
      end
      accepted = present && out_addr_ok;
      popped = !blocked && out_data_ok && q.size() > 0;
      orphan = !blocked && out_data_ok && q.size() == 0;
      head = popped ? q[0] : -1;

      exp_req = '0;
      if (present) begin
        if (own == 1) exp_req = {mem_ben, mem_din, mem_wr, mem_addr, 1'b0, accepted};
        else          exp_req = {if_ben, if_din, if_wr, if_addr, accepted, 1'b0};
      end
      exp_rsp = {head == 0, head == 1,
                 (head == 0) ? out_dout : 32'h0,
                 (head == 1) ? out_dout : 32'h0, err_m};
      check("model_req", {out_ben, out_din, out_wr, out_addr, if_addr_ok, mem_addr_ok}, exp_req);
      check("model_rsp", {if_data_ok, mem_data_ok, if_dout, mem_dout, err_orphan}, exp_rsp);

      if (reset) begin
        q.delete();
        pending = -1;
        starve = 0;
        err_m = 1'b0;
        after_rst = 1'b1;
      end else begin
        after_rst = 1'b0;
        if (popped) void'(q.pop_front());
        if (accepted) q.push_back(own);
        pending = (present && !accepted) ? own : -1;
        if (orphan) err_m = 1'b1;
        if (accepted && own == 0) starve = 0;
        else if (if_ben == 0) starve = 0;
        else if (accepted && own == 1 && starve < LIMIT) starve++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0] g;
    // Reset cycle: a data request is present but must be ignored.
    mem_ben = 4'hF; mem_addr = 32'h100; out_addr_ok = 1'b1;
    neg();
    check("rst_out_ben", out_ben, 4'h0);
    check("rst_mem_aok", mem_addr_ok, 1'b0);
    nxt();
    reset = 1'b0;
    neg();
    check("post_rst_out_ben", out_ben, 4'h0);
    check("post_rst_aok", mem_addr_ok, 1'b0);
    nxt();
    $display("txn reset released");

    // Data read: accepted in cycle 1, response in cycle 3.
    neg();
    check("rd_out_ben", out_ben, 4'hF);
    check("rd_out_addr", out_addr, 32'h100);
    check("rd_mem_aok", mem_addr_ok, 1'b1);
    nxt();
    mem_ben = 4'h0; out_addr_ok = 1'b0;
    neg();
    check("rd_early_dok", mem_data_ok, 1'b0);
    nxt();
    out_data_ok = 1'b1; out_dout = 32'hDEAD;
    neg();
    check("rd_mem_dok", mem_data_ok, 1'b1);
    check("rd_mem_dout", mem_dout, 32'hDEAD);
    check("rd_if_dok", if_data_ok, 1'b0);
    nxt();
    out_data_ok = 1'b0;
    $display("txn data read 0x100 -> 0xDEAD");

    // Both ports request every cycle: 8 data grants, then 1 instruction grant.
    if_ben = 4'hF; if_addr = 32'h400; mem_ben = 4'hF; mem_addr = 32'h500; out_addr_ok = 1'b1;
    for (int k = 0; k < 18; k++) begin
      out_dout = 32'(k);
      neg();
      g = ((k % 9) == 8) ? 2'b10 : 2'b01;
      check($sformatf("starve_grant_%0d", k), {if_addr_ok, mem_addr_ok}, g);
      $display("txn grant %0d if=%0b mem=%0b", k, if_addr_ok, mem_addr_ok);
      nxt();
      out_data_ok = 1'b1;
    end
    if_ben = 4'h0; mem_ben = 4'h0; out_addr_ok = 1'b0;
    neg();
    nxt();
    out_data_ok = 1'b0;

    // Stall: the instruction owner holds while mem_ben rises mid-stall.
    if_ben = 4'hF; if_addr = 32'h200; if_wr = 1'b1; if_din = 32'hCAFE;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin mem_ben = 4'hF; mem_addr = 32'h300; end
      neg();
      check($sformatf("stall_addr_%0d", k), out_addr, 32'h200);
      check($sformatf("stall_aok_%0d", k), {if_addr_ok, mem_addr_ok}, 2'b00);
      nxt();
    end
    out_addr_ok = 1'b1;
    neg();
    check("stall_if_aok", if_addr_ok, 1'b1);
    check("stall_wr", out_wr, 1'b1);
    nxt();
    if_ben = 4'h0; if_wr = 1'b0;
    neg();
    check("stall_mem_addr", out_addr, 32'h300);
    check("stall_mem_aok", mem_addr_ok, 1'b1);
    nxt();
    mem_ben = 4'h0; out_addr_ok = 1'b0; out_data_ok = 1'b1; out_dout = 32'h11;
    neg();
    check("stall_if_dok", if_data_ok, 1'b1);
    nxt();
    out_dout = 32'h22;
    neg();
    check("stall_mem_dout", mem_dout, 32'h22);
    nxt();
    out_data_ok = 1'b0;
    $display("txn stall held instruction 0x200");

    // Fill the FIFO, then check that a pop frees the slot one cycle later.
    mem_ben = 4'hF; out_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_addr = 32'h1000 + 32'(4 * k);
      neg();
      check($sformatf("fill_aok_%0d", k), mem_addr_ok, 1'b1);
      nxt();
    end
    neg();
    check("full_out_ben", out_ben, 4'h0);
    check("full_aok", mem_addr_ok, 1'b0);
    nxt();
    out_data_ok = 1'b1; out_dout = 32'h33;
    neg();
    check("full_pop_ben", out_ben, 4'h0);
    check("full_pop_dok", mem_data_ok, 1'b1);
    nxt();
    out_data_ok = 1'b0;
    neg();
    check("full_next_ben", out_ben, 4'hF);
    check("full_next_aok", mem_addr_ok, 1'b1);
    nxt();
    mem_ben = 4'h0; out_addr_ok = 1'b0; out_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      neg();
      check($sformatf("drain_dok_%0d", k), mem_data_ok, 1'b1);
      nxt();
    end
    out_data_ok = 1'b0;
    $display("txn fifo full and drain");

    // Interleaved if/mem/if, with push and pop in the same cycle.
    if_ben = 4'hF; if_addr = 32'h40; out_addr_ok = 1'b1;
    neg(); check("rt_if_aok0", if_addr_ok, 1'b1); nxt();
    if_ben = 4'h0; mem_ben = 4'hF; mem_addr = 32'h50; out_data_ok = 1'b1; out_dout = 32'h1;
    neg();
    check("rt_mem_aok", mem_addr_ok, 1'b1);
    check("rt_resp1", {if_data_ok, mem_data_ok, if_dout}, {2'b10, 32'h1});
    nxt();
    mem_ben = 4'h0; if_ben = 4'hF; if_addr = 32'h60; out_dout = 32'h2;
    neg();
    check("rt_if_aok1", if_addr_ok, 1'b1);
    check("rt_resp2", {if_data_ok, mem_data_ok, mem_dout}, {2'b01, 32'h2});
    nxt();
    if_ben = 4'h0; out_addr_ok = 1'b0; out_dout = 32'h3;
    neg();
    check("rt_resp3", {if_data_ok, mem_data_ok, if_dout}, {2'b10, 32'h3});
    nxt();
    out_data_ok = 1'b0;
    $display("txn routed 0x1 0x2 0x3 to if mem if");

    // Orphan response.
    out_data_ok = 1'b1; out_dout = 32'h77;
    neg();
    check("orph_same_cycle", {err_orphan, if_data_ok, mem_data_ok}, 3'b000);
    nxt();
    out_data_ok = 1'b0;
    neg(); check("orph_set", err_orphan, 1'b1); nxt();
    neg(); check("orph_sticky", err_orphan, 1'b1); nxt();
    $display("txn orphan response flagged");

    // Reset with 3 requests in flight.
    mem_ben = 4'hF; out_addr_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_addr = 32'h2000 + 32'(k);
      neg(); check($sformatf("pre_rst_aok_%0d", k), mem_addr_ok, 1'b1); nxt();
    end
    reset = 1'b1; out_data_ok = 1'b1;
    neg();
    check("mid_rst_outs", {out_ben, mem_addr_ok, mem_data_ok, if_data_ok}, 7'h0);
    nxt();
    reset = 1'b0; out_data_ok = 1'b0; mem_ben = 4'h0; out_addr_ok = 1'b0;
    neg();
    check("after_rst_outs", {out_ben, out_addr, err_orphan, mem_data_ok, if_data_ok}, 39'h0);
    nxt();
    out_data_ok = 1'b1;
    neg();
    check("after_rst_empty", {if_data_ok, mem_data_ok}, 2'b00);
    nxt();
    out_data_ok = 1'b0;
    neg();
    check("after_rst_orphan", err_orphan, 1'b1);
    nxt();
    $display("txn reset with 3 in flight");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
